sram_arbiter: RTL

- Sequences the external asynchronous 8-bit SRAM (256 KiB, 18-bit address) and shares it between two bus masters.
- Master 0 is the Z80 CPU bus of z80computer. Master 1 is a secondary requester, such as a UART loader or DMA engine.
- Replaces the direct combinational wiring of CPU strobes to the SRAM pins.
- Generates cs/oe/we timing with a programmable number of access wait cycles, and returns a one-cycle ack per completed transfer.

---
 rtl/sram_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-master round-robin sequencer for an external async 8-bit SRAM.
// Each transfer walks IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE -> IDLE.
// Every strobe and data output is a flop, so the pins carry no combinational glitches.
module sram_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_m0_cs,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [7:0]        i_m0_dat,
  output logic [7:0]        o_m0_dat,
  output logic              o_m0_ack,
  input  logic              i_m1_cs,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [7:0]        i_m1_dat,
  output logic [7:0]        o_m1_dat,
  output logic              o_m1_ack,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [7:0]        o_sram_dat,
  output logic              o_sram_dat_oe,
  input  logic [7:0]        i_sram_dat,
  output logic              o_sram_cs_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_busy
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            state;
  logic              last_grant;  // master served most recently
  logic              gnt;         // master owning the current transfer
  logic              lat_we;      // direction of the current transfer
  logic [CNT_W-1:0]  cnt;

  logic              pick;
  logic              req_any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_dat;

  // Arbitration: a lone requester wins; on a tie the master not served last wins.
  always_comb begin
    pick = 1'b0;
    if (i_m0_cs && i_m1_cs) pick = ~last_grant;
    else if (i_m1_cs)       pick = 1'b1;
    req_any  = i_m0_cs | i_m1_cs;
    sel_we   = pick ? i_m1_we   : i_m0_we;
    sel_addr = pick ? i_m1_addr : i_m0_addr;
    sel_dat  = pick ? i_m1_dat  : i_m0_dat;
  end

  // Transfer sequencer; the address/data/we of the winner are captured at grant,
  // so later changes on the master side cannot disturb an ongoing cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      gnt           <= 1'b0;
      lat_we        <= 1'b0;
      cnt           <= '0;
      o_sram_addr   <= '0;
      o_sram_dat    <= '0;
      o_sram_dat_oe <= 1'b0;
      o_sram_cs_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_we_n   <= 1'b1;
      o_m0_ack      <= 1'b0;
      o_m1_ack      <= 1'b0;
      o_m0_dat      <= '0;
      o_m1_dat      <= '0;
      o_busy        <= 1'b0;
    end else begin
      o_m0_ack <= 1'b0;
      o_m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            state         <= SETUP;
            gnt           <= pick;
            last_grant    <= pick;
            lat_we        <= sel_we;
            o_sram_addr   <= sel_addr;
            o_sram_dat    <= sel_dat;
            o_sram_cs_n   <= 1'b0;
            o_sram_oe_n   <= sel_we;   // reads open the output buffer right away
            o_sram_we_n   <= 1'b1;     // writes get one cycle of address setup
            o_sram_dat_oe <= sel_we;
            o_busy        <= 1'b1;
          end
        end
        SETUP: begin
          state <= ACCESS;
          cnt   <= CNT_W'(WAIT_CYCLES - 1);
          if (lat_we) o_sram_we_n <= 1'b0;
        end
        ACCESS: begin
          if (cnt == '0) begin
            state <= DONE;
            if (lat_we) begin
              // release the strobe but keep cs, address and data for hold time
              o_sram_we_n <= 1'b1;
            end else begin
              o_sram_cs_n <= 1'b1;
              o_sram_oe_n <= 1'b1;
              if (gnt) o_m1_dat <= i_sram_dat;
              else     o_m0_dat <= i_sram_dat;
            end
            if (gnt) o_m1_ack <= 1'b1;
            else     o_m0_ack <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state         <= IDLE;
          o_sram_cs_n   <= 1'b1;
          o_sram_oe_n   <= 1'b1;
          o_sram_we_n   <= 1'b1;
          o_sram_dat_oe <= 1'b0;
          o_busy        <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
